// File: rtl/md_pkg.sv
// md_pkg: shared opcode encodings, default latencies and counter width for the MD sequencer.
package md_pkg;
   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } md_op_e;
   typedef enum logic {ST_IDLE, ST_RUN} md_state_e;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int CNT_W        = 4;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product or {remainder, quotient}; divider present only with MD_DIV_EN.
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div0_o
);
   logic        sgn;
   logic [63:0] ea, eb;
`ifdef MD_DIV_EN
   logic        dsg, na, nb, is_div;
   logic [31:0] ua, ub, dv, uq, ur;
`endif
   always_comb begin
      sgn = (op_i == OP_MULT);
      ea  = {{32{sgn & a_i[31]}}, a_i};
      eb  = {{32{sgn & b_i[31]}}, b_i};
`ifdef MD_DIV_EN
      // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend.
      is_div = (op_i == OP_DIV) | (op_i == OP_DIVU);
      dsg    = (op_i == OP_DIV);
      na     = dsg & a_i[31];
      nb     = dsg & b_i[31];
      ua     = na ? -a_i : a_i;
      ub     = nb ? -b_i : b_i;
      div0_o = is_div & (b_i == 32'd0);
      dv     = div0_o ? 32'd1 : ub;
      uq     = ua / dv;
      ur     = ua % dv;
      res_o  = is_div ? {na ? -ur : ur, (na ^ nb) ? -uq : uq} : ea * eb;
`else
      div0_o = 1'b0;
      res_o  = ea * eb;
`endif
   end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide sequencer owning HI/LO, with fixed-latency busy counter and D-stage stall.
// Divide support is compiled in only when MD_DIV_EN is defined; otherwise DIV/DIVU behave as NONE.
module md_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   output logic        busy,
   output logic        stall,
   output logic [31:0] out,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             wr_q, wr_d;
   logic [63:0]      res;
   logic             div0, is_mul, is_div, acc;
   md_state_e        st;

   md_arith u_arith (
      .op_i   (op),
      .a_i    (A),
      .b_i    (B),
      .res_o  (res),
      .div0_o (div0)
   );

   assign is_mul = (op == OP_MULT) | (op == OP_MULTU);
`ifdef MD_DIV_EN
   assign is_div = (op == OP_DIV) | (op == OP_DIVU);
`else
   assign is_div = 1'b0;
`endif
   assign st    = (cnt_q != '0) ? ST_RUN : ST_IDLE;
   assign busy  = (st == ST_RUN);
   assign acc   = start & ~cancel & ~busy;
   assign stall = busy | (start & ~cancel & (is_mul | is_div));
   assign out   = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      wr_d     = wr_q;
      if (st == ST_RUN) begin
         cnt_d = cnt_q - 1'b1;
         // A divide-by-zero still runs its full latency but never commits.
         if (cnt_q == CNT_W'(1) && wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
      end else if (acc && (is_mul || is_div)) begin
         cnt_d    = is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
         res_hi_d = res[63:32];
         res_lo_d = res[31:0];
         wr_d     = ~div0;
      end else if (acc) begin
         hi_d = (op == OP_MTHI) ? A : hi_q;
         lo_d = (op == OP_MTLO) ? A : lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         wr_q     <= wr_d;
      end
   end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: randomized scoreboard bench for md_ctrl against an arithmetic reference model of HI/LO.
module tb_md_ctrl;
   import md_pkg::*;
   localparam int ML = 5;
   localparam int DL = 10;
`ifdef MD_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] A = '0, B = '0;
   logic        busy, stall;
   logic [31:0] out, hi, lo;

   exp_t        sb[$];
   logic [31:0] m_hi = '0, m_lo = '0;
   int          n_chk = 0, n_fail = 0, run_cnt = 0;

   md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .cancel(cancel),
      .busy(busy), .stall(stall), .out(out), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic bit is_long(input logic [3:0] o);
      return (o == 4'd1) || (o == 4'd2) || (DIV_ON && (o == 4'd3 || o == 4'd4));
   endfunction

   function automatic logic [31:0] exp_out(input logic [3:0] o);
      return (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0;
   endfunction

   // Reference arithmetic computed with wide integer math: returns {HI, LO}.
   function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          s;
      longint          r;
      longint unsigned u;
      case (o)
         4'd1: begin s = longint'($signed(a)) * longint'($signed(b)); return s; end
         4'd2: begin u = 64'(a) * 64'(b); return u; end
         4'd3: begin
            s = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            return {r[31:0], s[31:0]};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   // Monitor: measures each busy window and checks the committed HI/LO when it closes.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (reset) run_cnt = 0;
      else if (busy) run_cnt++;
      else if (run_cnt != 0) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: busy window of %0d cycles with no expected operation", run_cnt);
         end else begin
            e = sb.pop_front();
            chk("done_hi", hi, e.hi);
            chk("done_lo", lo, e.lo);
            chk("busy_len", run_cnt, e.lat);
         end
         run_cnt = 0;
      end
   end

   task automatic idle();
      @(negedge clk);
      start = 1'b0;
      cancel = 1'b0;
      op = 4'd0;
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
      logic [63:0] r;
      logic [31:0] eh, el;
      int          lat;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b; cancel = c;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_hi", hi, m_hi);
      chk("idle_lo", lo, m_lo);
      chk("req_stall", stall, is_long(o) && !c);
      chk("req_out", out, exp_out(o));
      if (c) return;
      if (is_long(o)) begin
         lat = (o <= 4'd2) ? ML : DL;
         r = ((o == 4'd3 || o == 4'd4) && b == 0) ? {m_hi, m_lo} : ref_res(o, a, b);
         eh = r[63:32];
         el = r[31:0];
         sb.push_back('{eh, el, lat});
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            op = (i == 0) ? 4'd7 : 4'($urandom_range(0, 9));
            A = $urandom; B = $urandom;
            cancel = ($urandom_range(0, 3) == 0);
            #1;
            chk("run_stall", stall, 1);
            chk("run_out", out, exp_out(op));
         end
         m_hi = eh;
         m_lo = el;
      end else if (o == 4'd5) m_hi = a;
      else if (o == 4'd6) m_lo = a;
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return 32'($signed($urandom_range(0, 40)) - 20);
         2: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
         default: return 32'($urandom_range(0, 9));
      endcase
   endfunction

   initial begin
      logic [3:0] lop;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_stall", stall, 0);

      issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle();
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle();
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle();
`ifdef MD_DIV_EN
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);
`endif
      issue(4'd4, 32'd7, 32'd2, 1'b0);
      idle();
`ifdef MD_DIV_EN
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);
`endif
      issue(4'd5, 32'h1234, 32'd0, 1'b0);
      issue(4'd6, 32'h5678, 32'd0, 1'b0);
      issue(4'd3, 32'd99, 32'd0, 1'b0);
      idle();
      chk("div0_hi", hi, 32'h1234);
      chk("div0_lo", lo, 32'h5678);

      issue(4'd1, 32'd3, 32'd4, 1'b1);
      idle();
      chk("cancel_busy", busy, 0);

      lop = DIV_ON ? 4'd3 : 4'd1;
      @(negedge clk);
      start = 1'b1; op = lop; A = 32'd100; B = 32'd7; cancel = 1'b0;
      sb.push_back('{32'd0, 32'd0, 0});
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      reset = 1'b0;

      for (int n = 0; n < 150; n++)
         issue(4'($urandom_range(0, 9)), rnd_opnd(), rnd_opnd(), ($urandom_range(0, 7) == 0));
      repeat (3) idle();
      chk("final_hi", hi, m_hi);
      chk("final_lo", lo, m_lo);
      chk("sb_drain", 64'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
